// File: rtl/z80_bus_responder.sv
`default_nettype none
// ============================================================================
// z80_bus_responder : Z80 memory/IO bus target with WAIT insertion and IM2 ack
// Revision 1.0
// ============================================================================
module z80_bus_responder #(
  parameter int         AW          = 12,
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] IO_PORT     = 8'h10,
  parameter logic [7:0] VECTOR      = 8'hE0
) (
  input  logic          wb_clk_i,
  input  logic          rst_n,
  input  logic [15:0]   addr,
  input  logic [7:0]    cpu_data,
  output logic [7:0]    data_out,
  output logic          data_oe,
  input  logic          m1_n,
  input  logic          mreq_n,
  input  logic          iorq_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic          rfsh_n,
  output logic          wait_n,
  output logic          int_n,
  input  logic          irq,
  input  logic [7:0]    io_in,
  output logic [7:0]    io_out,
  output logic          io_wr_stb,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_MEMRD = 3'd0,
    K_MEMWR = 3'd1,
    K_IORD  = 3'd2,
    K_IOWR  = 3'd3,
    K_INTA  = 3'd4
  } kind_t;

  localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_STATES - 1);
  localparam bit         c_HAS_WAIT  = (WAIT_STATES > 0);

  state_t        r_state, w_state_nxt;
  kind_t         r_kind, w_kind_nxt, w_kind_det;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [7:0]    r_data_out, w_data_out_nxt;
  logic          r_data_oe, w_data_oe_nxt;
  logic          r_wait_n;
  logic [7:0]    r_io_out, w_io_out_nxt;
  logic          r_io_wr_stb, w_io_stb_nxt;
  logic          r_pending;
  logic          r_irq_d;
  logic          r_armed;
  logic          w_rec, w_cpu_we, w_ack;
  logic          w_bus_idle, w_io_hit, w_irq_rise;
  logic [AW-1:0] w_ram_addr;
  logic          w_unused_addr;
  logic [7:0]    r_mem [0:(1<<AW)-1];

  assign w_bus_idle    = mreq_n & iorq_n & rd_n & wr_n;
  assign w_io_hit      = (addr[7:0] == IO_PORT);
  assign w_ram_addr    = addr[AW-1:0];
  assign w_irq_rise    = irq & ~r_irq_d;
  assign w_unused_addr = ^addr;

  always_comb begin
    w_state_nxt    = r_state;
    w_kind_nxt     = r_kind;
    w_kind_det     = K_MEMRD;
    w_cnt_nxt      = r_cnt;
    w_data_out_nxt = r_data_out;
    w_data_oe_nxt  = r_data_oe;
    w_io_out_nxt   = r_io_out;
    w_io_stb_nxt   = 1'b0;
    w_cpu_we       = 1'b0;
    w_ack          = 1'b0;
    w_rec          = 1'b0;

    // Refresh and IO cycles to other ports fall through unrecognised
    if (!mreq_n && !rd_n && rfsh_n) begin
      w_rec = 1'b1;  w_kind_det = K_MEMRD;
    end else if (!mreq_n && !wr_n) begin
      w_rec = 1'b1;  w_kind_det = K_MEMWR;
    end else if (!iorq_n && !m1_n) begin
      w_rec = 1'b1;  w_kind_det = K_INTA;
    end else if (!iorq_n && !rd_n && w_io_hit) begin
      w_rec = 1'b1;  w_kind_det = K_IORD;
    end else if (!iorq_n && !wr_n && w_io_hit) begin
      w_rec = 1'b1;  w_kind_det = K_IOWR;
    end

    case (r_state)
      S_IDLE: begin
        if (r_armed && w_rec) begin
          w_kind_nxt  = w_kind_det;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = c_HAS_WAIT ? S_WAIT : S_ACTIVE;
        end
      end
      S_WAIT: begin
        if (r_cnt == c_WAIT_LAST) w_state_nxt = S_ACTIVE;
        else                      w_cnt_nxt   = r_cnt + 4'd1;
      end
      S_ACTIVE: begin
        w_state_nxt = S_DONE;
        case (r_kind)
          K_MEMRD: begin w_data_out_nxt = r_mem[w_ram_addr]; w_data_oe_nxt = 1'b1; end
          K_MEMWR: w_cpu_we = 1'b1;
          K_IORD:  begin w_data_out_nxt = io_in; w_data_oe_nxt = 1'b1; end
          K_IOWR:  begin w_io_out_nxt = cpu_data; w_io_stb_nxt = 1'b1; end
          K_INTA:  begin w_data_out_nxt = VECTOR; w_data_oe_nxt = 1'b1; w_ack = 1'b1; end
          default: w_state_nxt = S_DONE;
        endcase
      end
      S_DONE: begin
        if (w_bus_idle) begin
          w_state_nxt   = S_IDLE;
          w_data_oe_nxt = 1'b0;
        end else if (!wr_n) begin
          w_data_oe_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_kind      <= K_MEMRD;
      r_cnt       <= 4'd0;
      r_data_out  <= 8'h00;
      r_data_oe   <= 1'b0;
      r_wait_n    <= 1'b1;
      r_io_out    <= 8'h00;
      r_io_wr_stb <= 1'b0;
      r_pending   <= 1'b0;
      r_irq_d     <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_kind      <= w_kind_nxt;
      r_cnt       <= w_cnt_nxt;
      r_data_out  <= w_data_out_nxt;
      r_data_oe   <= w_data_oe_nxt;
      r_wait_n    <= (w_state_nxt != S_WAIT);
      r_io_out    <= w_io_out_nxt;
      r_io_wr_stb <= w_io_stb_nxt;
      r_irq_d     <= irq;
      // A new request in the acknowledge cycle must not be lost
      r_pending   <= w_irq_rise ? 1'b1 : (w_ack ? 1'b0 : r_pending);
      r_armed     <= r_armed | w_bus_idle;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_cpu_we && !(ld_we && (ld_addr == w_ram_addr))) r_mem[w_ram_addr] <= cpu_data;
    if (ld_we) r_mem[ld_addr] <= ld_data;
  end

  assign data_out  = r_data_out;
  assign data_oe   = r_data_oe;
  assign wait_n    = r_wait_n;
  assign int_n     = ~r_pending;
  assign io_out    = r_io_out;
  assign io_wr_stb = r_io_wr_stb;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_responder.sv
`default_nettype none
// ============================================================================
// tb_z80_bus_responder : two responders (0 and 3 wait states) on one bus,
// checked against a cycle-level reference model. Revision 1.0
// ============================================================================
module tb_z80_bus_responder;
  localparam int         AW   = 12;
  localparam logic [7:0] VEC  = 8'hE0;
  localparam logic [7:0] PORT = 8'h10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   addr;
  logic [7:0]    cpu_data, io_in, ld_data;
  logic          m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, irq, ld_we;
  logic [AW-1:0] ld_addr;
  logic [7:0]    dout [2];
  logic [7:0]    iout [2];
  logic          oe [2], waitn [2], intn [2], stb [2];

  bit [7:0] mem [2][4096];
  bit       pend [2];
  bit [7:0] mio [2];
  bit       irq_q;
  int       ncmp = 0;
  int       nfail = 0;
  logic [11:0] pa [8];

  always #5 clk = ~clk;

  z80_bus_responder #(.AW(AW), .WAIT_STATES(0), .IO_PORT(PORT), .VECTOR(VEC)) u_dut0 (
    .wb_clk_i(clk), .rst_n(rst_n), .addr(addr), .cpu_data(cpu_data),
    .data_out(dout[0]), .data_oe(oe[0]), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .wait_n(waitn[0]), .int_n(intn[0]),
    .irq(irq), .io_in(io_in), .io_out(iout[0]), .io_wr_stb(stb[0]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  z80_bus_responder #(.AW(AW), .WAIT_STATES(3), .IO_PORT(PORT), .VECTOR(VEC)) u_dut3 (
    .wb_clk_i(clk), .rst_n(rst_n), .addr(addr), .cpu_data(cpu_data),
    .data_out(dout[1]), .data_oe(oe[1]), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .wait_n(waitn[1]), .int_n(intn[1]),
    .irq(irq), .io_in(io_in), .io_out(iout[1]), .io_wr_stb(stb[1]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; irq edge sets pending, otherwise an ack clears it
  task automatic tick(input bit ack0, input bit ack3);
    bit rise;
    @(posedge clk);
    rise = irq && !irq_q;
    if (rise) begin pend[0] = 1'b1; pend[1] = 1'b1; end
    else begin
      if (ack0) pend[0] = 1'b0;
      if (ack3) pend[1] = 1'b0;
    end
    irq_q = irq;
    @(negedge clk);
  endtask

  task automatic strobes_idle();
    m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1;
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d wait_n", tag, d), 8'(waitn[d]), 8'd1);
      chk($sformatf("%s d%0d data_oe", tag, d), 8'(oe[d]), 8'd0);
      chk($sformatf("%s d%0d int_n", tag, d), 8'(intn[d]), 8'(!pend[d]));
      chk($sformatf("%s d%0d io_out", tag, d), iout[d], mio[d]);
      chk($sformatf("%s d%0d io_wr_stb", tag, d), 8'(stb[d]), 8'd0);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] v);
    ld_we = 1; ld_addr = a; ld_data = v;
    tick(0, 0);
    ld_we = 0;
    mem[0][a] = v; mem[1][a] = v;
  endtask

  task automatic irq_pulse(input string tag);
    irq = 1;
    tick(0, 0);
    for (int d = 0; d < 2; d++) chk($sformatf("%s d%0d int_n", tag, d), 8'(intn[d]), 8'd0);
    irq = 0;
    tick(0, 0);
  endtask

  // kind: 0 MEMRD 1 MEMWR 2 IORD 3 IOWR 4 INTA 5 refresh
  task automatic bus_cycle(input string tag, input int kind, input logic [15:0] a,
                           input logic [7:0] wd, input logic [7:0] iov,
                           input int irq_at, input int ld_at,
                           input logic [11:0] la, input logic [7:0] ldv);
    bit       rec, rd, act;
    logic [7:0] rv [2];
    rv[0] = 8'h00; rv[1] = 8'h00;
    addr = a; cpu_data = wd; io_in = iov;
    strobes_idle();
    case (kind)
      0: begin mreq_n = 0; rd_n = 0; end
      1: begin mreq_n = 0; wr_n = 0; end
      2: begin iorq_n = 0; rd_n = 0; end
      3: begin iorq_n = 0; wr_n = 0; end
      4: begin iorq_n = 0; m1_n = 0; end
      default: begin mreq_n = 0; rfsh_n = 0; end
    endcase
    rec = (kind == 0) || (kind == 1) || (kind == 4) ||
          (((kind == 2) || (kind == 3)) && (a[7:0] == PORT));
    rd  = (kind == 0) || (kind == 2) || (kind == 4);
    for (int e = 0; e < 6; e++) begin
      if (e == irq_at) irq = 1;
      ld_we = (e == ld_at); ld_addr = la; ld_data = ldv;
      for (int d = 0; d < 2; d++)
        if (rd && e == ws(d) + 1)
          rv[d] = (kind == 0) ? mem[d][a[11:0]] : (kind == 2) ? iov : VEC;
      tick(rec && kind == 4 && e == ws(0) + 1, rec && kind == 4 && e == ws(1) + 1);
      for (int d = 0; d < 2; d++) begin
        act = rec && (e == ws(d) + 1);
        if (act && kind == 1) mem[d][a[11:0]] = wd;
        if (act && kind == 3) mio[d] = wd;
        if (e == ld_at) mem[d][la] = ldv;
        chk($sformatf("%s d%0d e%0d wait_n", tag, d, e), 8'(waitn[d]), 8'(!(rec && e < ws(d))));
        chk($sformatf("%s d%0d e%0d data_oe", tag, d, e), 8'(oe[d]), 8'(rec && rd && e >= ws(d) + 1));
        if (rec && rd && e >= ws(d) + 1)
          chk($sformatf("%s d%0d e%0d data_out", tag, d, e), dout[d], rv[d]);
        chk($sformatf("%s d%0d e%0d int_n", tag, d, e), 8'(intn[d]), 8'(!pend[d]));
        chk($sformatf("%s d%0d e%0d io_wr_stb", tag, d, e), 8'(stb[d]), 8'(act && kind == 3));
        chk($sformatf("%s d%0d e%0d io_out", tag, d, e), iout[d], mio[d]);
      end
    end
    ld_we = 0; irq = 0;
    strobes_idle();
    tick(0, 0);
    check_idle({tag, " release"});
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rdat;
    int          rk, ria;
    rst_n = 0; strobes_idle(); irq = 0; irq_q = 0; ld_we = 0; ld_addr = '0; ld_data = 0;
    addr = 0; cpu_data = 0; io_in = 0;
    pend[0] = 0; pend[1] = 0; mio[0] = 0; mio[1] = 0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("reset d%0d data_out", d), dout[d], 8'h00);
    check_idle("reset");
    rst_n = 1;
    tick(0, 0);

    preload(12'h005, 8'h3E);
    bus_cycle("memrd5", 0, 16'h0005, 8'h00, 8'h00, -1, -1, 12'h0, 8'h0);
    bus_cycle("memwr", 1, 16'h1234, 8'hA5, 8'h00, -1, -1, 12'h0, 8'h0);
    bus_cycle("memrd_alias", 0, 16'h0234, 8'h00, 8'h00, -1, -1, 12'h0, 8'h0);
    bus_cycle("iowr_hit", 3, 16'h0010, 8'h7C, 8'h00, -1, -1, 12'h0, 8'h0);
    bus_cycle("iowr_miss", 3, 16'h0011, 8'h55, 8'h00, -1, -1, 12'h0, 8'h0);
    bus_cycle("iord_hit", 2, 16'h0010, 8'h00, 8'h5A, -1, -1, 12'h0, 8'h0);
    bus_cycle("iord_miss", 2, 16'h0011, 8'h00, 8'h5A, -1, -1, 12'h0, 8'h0);
    irq_pulse("irq1");
    bus_cycle("inta", 4, 16'h00FF, 8'h00, 8'h00, -1, -1, 12'h0, 8'h0);
    bus_cycle("inta_nopend", 4, 16'h00FF, 8'h00, 8'h00, -1, -1, 12'h0, 8'h0);
    irq_pulse("irq2");
    bus_cycle("inta_coin4", 4, 16'h00FF, 8'h00, 8'h00, 4, -1, 12'h0, 8'h0);
    bus_cycle("inta_coin1", 4, 16'h00FF, 8'h00, 8'h00, 1, -1, 12'h0, 8'h0);
    bus_cycle("refresh", 5, 16'h0005, 8'h00, 8'h00, -1, -1, 12'h0, 8'h0);
    bus_cycle("ld_prio", 1, 16'h0777, 8'h11, 8'h00, -1, 4, 12'h777, 8'h99);
    bus_cycle("ld_prio_rd", 0, 16'h0777, 8'h00, 8'h00, -1, -1, 12'h0, 8'h0);

    for (int i = 0; i < 8; i++) begin
      pa[i] = 12'($urandom_range(0, 4095));
      preload(pa[i], 8'($urandom));
    end
    for (int i = 0; i < 30; i++) begin
      rk   = $urandom_range(0, 5);
      rdat = 8'($urandom);
      ria  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      if (rk == 2 || rk == 3)
        ra = {8'($urandom), (($urandom_range(0, 1) == 1) ? PORT : 8'($urandom))};
      else
        ra = {4'($urandom_range(0, 15)), pa[$urandom_range(0, 7)]};
      bus_cycle($sformatf("rnd%0d k%0d", i, rk), rk, ra, rdat, 8'($urandom), ria, -1, 12'h0, 8'h0);
    end

    // Reset in the middle of a waited read
    addr = 16'h0005; strobes_idle(); mreq_n = 0; rd_n = 0;
    tick(0, 0);
    tick(0, 0);
    chk("midrst d1 wait_n before", 8'(waitn[1]), 8'd0);
    chk("midrst d0 data_oe before", 8'(oe[0]), 8'd1);
    #2 rst_n = 0;
    #1;
    pend[0] = 0; pend[1] = 0; mio[0] = 0; mio[1] = 0;
    for (int d = 0; d < 2; d++) chk($sformatf("midrst d%0d data_out", d), dout[d], 8'h00);
    check_idle("midrst async");
    #1 rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick(0, 0);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("postrst%0d d%0d wait_n", k, d), 8'(waitn[d]), 8'd1);
        chk($sformatf("postrst%0d d%0d data_oe", k, d), 8'(oe[d]), 8'd0);
      end
    end
    strobes_idle();
    tick(0, 0);
    bus_cycle("recover_rd", 0, 16'h0005, 8'h00, 8'h00, -1, -1, 12'h0, 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Bus-side counterpart of the Z80 core: a memory and I/O target that answers the CPU's bus cycles in simulation and on the FPGA/board bring-up harness.
- Decodes the active-low control strobes (MREQ/IORQ/RD/WR/M1/RFSH) and the 16-bit address.
- Serves reads from a local RAM, latches writes, and provides one I/O port.
- Inserts programmable WAIT states, and raises INT_n with an IM2 vector returned on interrupt acknowledge.
- All CPU signals share wb_clk_i with the core; no synchronisers.

Parameters:
- AW, 12, RAM address width; RAM depth = 2^AW bytes; CPU address truncated to addr[AW-1:0] (aliasing/wrap).
- WAIT_STATES, 0, cycles wait_n is held low per memory/IO cycle (0..15).
- IO_PORT, 8'h10, I/O port number matched against addr[7:0].
- VECTOR, 8'hE0, byte driven on interrupt acknowledge.

Ports:
- wb_clk_i  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  16  CPU address bus
- cpu_data  in  8  CPU data-bus output (write data)
- data_out  out  8  data driven to CPU
- data_oe  out  1  1 = responder drives the data bus
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU control strobes, active low
- wait_n  out  1  to CPU WAIT, active low
- int_n  out  1  to CPU INT, active low
- irq  in  1  interrupt request from bench; rising edge sets pending
- io_in  in  8  value returned on I/O read of IO_PORT
- io_out  out  8  last byte written to IO_PORT
- io_wr_stb  out  1  one-cycle pulse on each IO_PORT write
- ld_we, ld_addr[AW-1:0], ld_data[7:0]  in  host preload port; writes RAM when ld_we=1

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; data_out=0, data_oe=0, wait_n=1, int_n=1, io_out=0, io_wr_stb=0, pending=0, wait counter=0. RAM contents are not reset.
- Reset asserted mid-cycle drops all outputs to reset values immediately; after release the FSM stays in IDLE until all strobes go high and a new cycle starts.
- Cycle classification, sampled in IDLE:
  - MEMRD: mreq_n=0, rd_n=0, rfsh_n=1.
  - MEMWR: mreq_n=0, wr_n=0.
  - IORD: iorq_n=0, m1_n=1, rd_n=0.
  - IOWR: iorq_n=0, m1_n=1, wr_n=0.
  - INTA: iorq_n=0, m1_n=0.
  - Refresh (mreq_n=0, rfsh_n=0) is ignored.
  - IO with addr[7:0]≠IO_PORT is ignored (no drive, no wait).
- FSM states: IDLE, WAIT, ACTIVE, DONE.
  - IDLE→WAIT if WAIT_STATES>0, else IDLE→ACTIVE, on a recognised cycle.
  - WAIT: wait_n=0, counter counts WAIT_STATES cycles, then →ACTIVE.
  - ACTIVE lasts 1 cycle, performs the action, then →DONE.
  - DONE: hold the read drive until all of mreq_n, iorq_n, rd_n, wr_n are 1, then →IDLE.
- Timing: a cycle detected at edge N gives wait_n low for edges N+1..N+W and data_oe=1 from edge N+W+1 until strobes release (same edge they are seen high).
- Actions in ACTIVE:
  - MEMRD: data_out = RAM[addr[AW-1:0]]; data_oe=1.
  - MEMWR: RAM[addr] ← cpu_data, exactly once per cycle.
  - IORD: data_out = io_in (sampled in ACTIVE); data_oe=1.
  - IOWR: io_out ← cpu_data; io_wr_stb=1 for that single cycle.
  - INTA: data_out=VECTOR; data_oe=1; pending ← 0.
- Interrupts:
  - Rising edge of irq (registered) sets pending; int_n = ~pending.
  - An irq edge in the same cycle as the INTA clear leaves pending=1 (set wins).
  - Ack without pending still returns VECTOR.
- Preload: ld_we write occurs the same cycle and has priority over a simultaneous MEMWR to the same address; the CPU write is dropped.
- data_oe is never 1 while wr_n=0.

Test Plan:
- Reset then preload RAM[0x005]=0x3E; MEMRD addr=0x0005, WAIT_STATES=0 -> data_oe=1, data_out=0x3E one cycle after detection, wait_n stays 1, data_oe drops when rd_n rises.
- WAIT_STATES=3; MEMWR addr=0x1234 data 0xA5 -> wait_n low exactly 3 cycles; subsequent MEMRD 0x0234 (AW=12 alias) returns 0xA5.
- IOWR addr=0x0010 data 0x7C -> io_out=0x7C, io_wr_stb high 1 cycle; IOWR addr=0x0011 -> io_out unchanged, no strobe, no wait; IORD 0x0010 with io_in=0x5A -> data_out=0x5A.
- irq rising edge -> int_n=0 next cycle; INTA (m1_n=0, iorq_n=0) -> data_out=0xE0, int_n=1 after ACTIVE; irq edge coincident with the ack -> int_n stays 0.
- Refresh cycle (mreq_n=0, rfsh_n=0, rd_n=1) -> no data_oe, no wait, FSM stays IDLE.
- Assert rst_n=0 during WAIT of a MEMRD -> wait_n=1, data_oe=0 immediately; after release with strobes still low, no response until strobes go high and a new cycle begins.
